// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 pooling over a raster stream of unsigned activations.
// Define AVG_POOL_EN to select rounded average pooling instead of maximum.
module maxpool_2x2 #(
    parameter int unsigned DATA_W = 21,
    parameter int unsigned IMG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned LBN = IMG_W / 2;
    localparam int unsigned LBW = (LBN > 1) ? $clog2(LBN) : 1;
`ifdef AVG_POOL_EN
    localparam int unsigned SW  = DATA_W + 1;
`else
    localparam int unsigned SW  = DATA_W;
`endif

    logic [CW-1:0]     c_q, c_d;
    logic              r_q, r_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic [SW-1:0]     lb_q [LBN];
    logic [SW-1:0]     lb_d [LBN];
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;

    logic [CW-1:0]     col;
    logic              row;
    logic [LBW-1:0]    idx;
    logic [SW-1:0]     pair;
    logic [DATA_W-1:0] win;
`ifdef AVG_POOL_EN
    logic [DATA_W+1:0] sum4;
`endif

    // An accepted start-of-frame sample is treated as column 0 of an even row.
    always_comb begin
        col  = i_sof ? '0 : c_q;
        row  = i_sof ? 1'b0 : r_q;
        idx  = LBW'(col >> 1);
`ifdef AVG_POOL_EN
        pair = SW'(h_q) + SW'(i_data);
        sum4 = (DATA_W+2)'(lb_q[idx]) + (DATA_W+2)'(pair) + (DATA_W+2)'(2);
        win  = sum4[DATA_W+1:2];
`else
        pair = (h_q > i_data) ? h_q : i_data;
        win  = (lb_q[idx] > pair) ? lb_q[idx] : pair;
`endif
    end

    always_comb begin
        c_d       = c_q;
        r_d       = r_q;
        h_d       = h_q;
        lb_d      = lb_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        if (i_valid) begin
            if (!col[0]) begin
                h_d = i_data;
            end else if (!row) begin
                lb_d[idx] = pair;
            end else begin
                o_data_d  = win;
                o_valid_d = 1'b1;
            end
            if (col == CW'(IMG_W - 1)) begin
                c_d = '0;
                r_d = ~row;
            end else begin
                c_d = col + CW'(1);
                r_d = row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q       <= '0;
            r_q       <= 1'b0;
            h_q       <= '0;
            lb_q      <= '{default: '0};
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            c_q       <= c_d;
            r_q       <= r_d;
            h_q       <= h_d;
            lb_q      <= lb_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule
